obi_mem_responder: RTL and testbench

// - OBI slave memory sitting directly downstream of the core's instruction or data memory port
//   (req/gnt/rvalid/addr/we/be/wdata/rdata). Instantiated once per port.
// - Accepts requests, applies byte-enabled writes and returns in-order read data after a fixed latency.
// - Bounds outstanding transactions and supports externally driven grant stalls for backpressure testing.

---
 rtl/obi_mem_pkg.sv | 12 +
 rtl/obi_resp_fifo.sv | 60 ++++++
 rtl/obi_mem_responder.sv | 113 +++++++++++
 tb/tb_obi_mem_responder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_mem_pkg.sv
// Shared types and constants for the OBI memory responder.
package obi_mem_pkg;

    localparam int unsigned OBI_DATA_WIDTH = 32;
    localparam logic [OBI_DATA_WIDTH-1:0] OOR_RDATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [OBI_DATA_WIDTH-1:0] rdata;
        logic [2:0]                age;
    } resp_entry_t;

endpackage

// File: rtl/obi_resp_fifo.sv
// In-order response queue: circular buffer of response entries whose ages
// advance every cycle, saturating at AGE_MAX.
module obi_resp_fifo
    import obi_mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned AGE_MAX = 1,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  resp_entry_t      push_entry,
    input  logic             pop,
    output resp_entry_t      head,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    resp_entry_t      entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[PTR_W'(i)] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (entries[PTR_W'(i)].age < 3'(AGE_MAX)) begin
                    entries[PTR_W'(i)].age <= entries[PTR_W'(i)].age + 3'd1;
                end
            end
            if (push) begin
                entries[wr_ptr] <= push_entry;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign head = entries[rd_ptr];

endmodule

// File: rtl/obi_mem_responder.sv
// OBI slave memory: byte-enabled writes, fixed-latency in-order responses,
// bounded outstanding transactions and externally stallable grant.
module obi_mem_responder
  import obi_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MEM_WORDS       = 16384,
  parameter int unsigned RVALID_LAT      = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter string       INIT_FILE       = ""
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 req_i,
  output logic                                 gnt_o,
  input  logic [ADDR_WIDTH-1:0]                addr_i,
  input  logic                                 we_i,
  input  logic [DATA_WIDTH/8-1:0]              be_i,
  input  logic [DATA_WIDTH-1:0]                wdata_i,
  output logic                                 rvalid_o,
  output logic [DATA_WIDTH-1:0]                rdata_o,
  input  logic                                 gnt_stall_i,
  output logic                                 oor_err_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_WIDTH-3:0] WORDS_LIMIT = (ADDR_WIDTH-2)'(MEM_WORDS);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [ADDR_WIDTH-3:0] word_idx;
  logic [IDX_W-1:0]      mem_idx;
  logic                  in_range;
  logic                  accept;
  logic                  resp_now;
  logic                  head_due;
  logic [DATA_WIDTH-1:0] resp_data;
  resp_entry_t           head;
  resp_entry_t           push_entry;
  logic [CNT_W-1:0]      count;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^addr_i[1:0];
  assign word_idx        = addr_i[ADDR_WIDTH-1:2];
  assign mem_idx         = word_idx[IDX_W-1:0];
  assign in_range        = word_idx < WORDS_LIMIT;

  assign gnt_o  = rst_ni & req_i & ~gnt_stall_i & (count < CNT_W'(MAX_OUTSTANDING));
  assign accept = req_i & gnt_o;

  always_comb begin
    resp_data = '0;
    if (!we_i) begin
      resp_data = in_range ? mem[mem_idx] : DATA_WIDTH'(OOR_RDATA);
    end
  end

  // The grant cycle counts as age 1, so a queued entry is due when it
  // reaches RVALID_LAT-1 before the edge; with RVALID_LAT=1 the response
  // is issued straight from the accept edge and never enters the queue.
  assign resp_now   = accept && (RVALID_LAT == 1);
  assign head_due   = (count != '0) && (head.age == 3'(RVALID_LAT - 1));
  assign push_entry = '{rdata: resp_data, age: 3'd1};

  obi_resp_fifo #(
    .DEPTH   (MAX_OUTSTANDING),
    .AGE_MAX (RVALID_LAT)
  ) u_resp_fifo (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .push       (accept & ~resp_now),
    .push_entry (push_entry),
    .pop        (head_due),
    .head       (head),
    .count      (count)
  );

  assign outstanding_o = count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      oor_err_o <= 1'b0;
    end else begin
      rvalid_o <= resp_now | head_due;
      if (resp_now) begin
        rdata_o <= resp_data;
      end else if (head_due) begin
        rdata_o <= head.rdata;
      end else begin
        rdata_o <= '0;
      end
      if (accept && !in_range) begin
        oor_err_o <= 1'b1;
      end
    end
  end

  // Memory has no reset so contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (accept && we_i && in_range) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (be_i[b]) mem[mem_idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: a LAT=1 and a LAT=3 instance, checked against
// a timestamp-based reference model plus directed tables and sequences.
module tb_obi_mem_responder;

    localparam int unsigned WORDS = 32;
    localparam int unsigned MAXO  = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [3:0]  be_i = '0;
    logic [31:0] wdata_i = '0;
    logic        gnt_stall_i = 1'b0;

    logic        gnt_a, gnt_b, rvalid_a, rvalid_b, oor_a, oor_b;
    logic [31:0] rdata_a, rdata_b;
    logic [1:0]  outst_a, outst_b;

    logic        sel = 1'b0;
    logic        cur_gnt, cur_rvalid, cur_oor;
    logic [31:0] cur_rdata;
    logic [1:0]  cur_out;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        logic [31:0] rdata;
        int unsigned due;
    } pend_t;

    pend_t       pq[$];
    int unsigned edge_n = 0;
    logic [31:0] mm [2][WORDS];
    logic [1:0]  oor_m = '0;

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        stall;
        logic        exp_gnt;
        logic        exp_rv;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[14];

    always #5 clk_i = ~clk_i;

    obi_mem_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(WORDS),
        .RVALID_LAT(1), .MAX_OUTSTANDING(MAXO), .INIT_FILE("")
    ) dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_a), .gnt_o(gnt_a),
        .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_a), .rdata_o(rdata_a), .gnt_stall_i(gnt_stall_i),
        .oor_err_o(oor_a), .outstanding_o(outst_a)
    );

    obi_mem_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(WORDS),
        .RVALID_LAT(3), .MAX_OUTSTANDING(MAXO), .INIT_FILE("")
    ) dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_b), .gnt_o(gnt_b),
        .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_b), .rdata_o(rdata_b), .gnt_stall_i(gnt_stall_i),
        .oor_err_o(oor_b), .outstanding_o(outst_b)
    );

    assign cur_gnt    = sel ? gnt_b    : gnt_a;
    assign cur_rvalid = sel ? rvalid_b : rvalid_a;
    assign cur_rdata  = sel ? rdata_b  : rdata_a;
    assign cur_oor    = sel ? oor_b    : oor_a;
    assign cur_out    = sel ? outst_b  : outst_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (dut %0d, edge %0d): got %h, expected %h", name, sel, edge_n, act, exp);
        end
    endtask

    // One bus cycle: called and returns at a negedge.
    task automatic step(input logic req, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd, input logic stall,
                        output logic acc, output logic g, output logic rv, output logic [31:0] rd);
        int unsigned lat;
        int unsigned idx;
        logic [31:0] resp;
        logic        exp_rv;
        logic [31:0] exp_rd;
        lat         = sel ? 3 : 1;
        req_a       = req & ~sel;
        req_b       = req & sel;
        we_i        = we;
        addr_i      = addr;
        be_i        = be;
        wdata_i     = wd;
        gnt_stall_i = stall;
        #1;
        acc = req && !stall && (pq.size() < MAXO);
        g   = cur_gnt;
        chk("gnt", 32'(g), 32'(acc));
        @(posedge clk_i);
        edge_n++;
        if (acc) begin
            idx  = addr >> 2;
            resp = 32'h0;
            if (idx >= WORDS) begin
                oor_m[sel] = 1'b1;
                if (!we) resp = 32'hDEAD_BEEF;
            end else if (we) begin
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) mm[sel][idx][8*k +: 8] = wd[8*k +: 8];
                end
            end else begin
                resp = mm[sel][idx];
            end
            pq.push_back('{rdata: resp, due: edge_n + lat - 1});
        end
        exp_rv = 1'b0;
        exp_rd = '0;
        if (pq.size() > 0 && pq[0].due == edge_n) begin
            exp_rv = 1'b1;
            exp_rd = pq[0].rdata;
            void'(pq.pop_front());
        end
        #1;
        rv = cur_rvalid;
        rd = cur_rdata;
        chk("rvalid", 32'(rv), 32'(exp_rv));
        if (exp_rv) chk("rdata", rd, exp_rd);
        chk("outstanding", 32'(cur_out), 32'(pq.size()));
        chk("oor_err", 32'(cur_oor), 32'(oor_m[sel]));
        @(negedge clk_i);
    endtask

    task automatic idle(input int unsigned n);
        logic a, g, rv;
        logic [31:0] rd;
        for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b0, a, g, rv, rd);
    endtask

    // Retries until the model grants, bounded.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        logic a, g, rv;
        logic [31:0] rd;
        int unsigned tries;
        a = 1'b0;
        tries = 0;
        while (!a && tries < 20) begin
            step(1'b1, we, addr, be, wd, 1'b0, a, g, rv, rd);
            tries++;
        end
        if (!a) chk("issue_timeout", 32'(tries), 32'd0);
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        req_a       = ~sel;
        req_b       = sel;
        gnt_stall_i = 1'b0;
        we_i        = 1'b0;
        addr_i      = '0;
        #1;
        chk("reset_gnt", 32'(cur_gnt), 32'd0);
        chk("reset_rvalid", 32'(cur_rvalid), 32'd0);
        chk("reset_rdata", cur_rdata, 32'd0);
        chk("reset_outstanding", 32'(cur_out), 32'd0);
        chk("reset_oor", 32'(cur_oor), 32'd0);
        pq.delete();
        oor_m = '0;
        repeat (2) @(negedge clk_i);
        chk("reset_rvalid_held", 32'(cur_rvalid), 32'd0);
        req_a  = 1'b0;
        req_b  = 1'b0;
        rst_ni = 1'b1;
    endtask

    task automatic preload();
        for (int unsigned i = 0; i < WORDS; i++) issue(1'b1, 32'(i * 4), 4'hF, 32'h1000_0000 + 32'(i));
        idle(4);
    endtask

    task automatic random_phase(input int unsigned n);
        logic a, g, rv;
        logic [31:0] rd;
        for (int unsigned i = 0; i < n; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                 32'(($urandom_range(0, 39) << 2) | $urandom_range(0, 3)),
                 4'($urandom), $urandom, $urandom_range(0, 4) == 0, a, g, rv, rd);
        end
        idle(4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a, g, rv;
        logic [31:0] rd;
        logic [4:0]  gpat;
        int unsigned acc_n, cyc, rv_n, g_n, peak;
        logic [31:0] got;

        //          req  we    addr          be     wdata          stall gnt  rv    rdata
        tbl[0]  = '{1'b1, 1'b1, 32'h0000_0040, 4'hF, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'h0,         1'b0, 1'b1, 1'b1, 32'h1234_5678};
        tbl[2]  = '{1'b1, 1'b1, 32'h0000_0040, 4'h5, 32'hAABB_CCDD, 1'b0, 1'b1, 1'b1, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0000_0042, 4'hF, 32'h0,         1'b0, 1'b1, 1'b1, 32'h12BB_56DD};
        tbl[4]  = '{1'b0, 1'b0, 32'h0000_0040, 4'hF, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 1'b1, 32'h0000_007C, 4'hF, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, 32'h0000_007C, 4'hF, 32'h0,         1'b0, 1'b1, 1'b1, 32'hCAFE_F00D};
        tbl[8]  = '{1'b1, 1'b1, 32'h0000_0080, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 32'h0};
        tbl[9]  = '{1'b1, 1'b0, 32'h0000_0080, 4'hF, 32'h0,         1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF};
        tbl[10] = '{1'b1, 1'b1, 32'h0000_0100, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 32'h0};
        tbl[11] = '{1'b1, 1'b0, 32'h0000_0000, 4'hF, 32'h0,         1'b0, 1'b1, 1'b1, 32'h1000_0000};
        tbl[12] = '{1'b1, 1'b1, 32'h0000_0040, 4'h0, 32'h1111_1111, 1'b0, 1'b1, 1'b1, 32'h0};
        tbl[13] = '{1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'h0,         1'b0, 1'b1, 1'b1, 32'h12BB_56DD};

        // ---- instance A: RVALID_LAT=1 ----
        sel = 1'b0;
        @(negedge clk_i);
        do_reset();
        preload();
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wdata, tbl[i].stall, a, g, rv, rd);
            chk($sformatf("tbl%0d_gnt", i), 32'(g), 32'(tbl[i].exp_gnt));
            chk($sformatf("tbl%0d_rvalid", i), 32'(rv), 32'(tbl[i].exp_rv));
            if (tbl[i].exp_rv) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
        end
        idle(3);
        chk("oor_sticky", 32'(cur_oor), 32'd1);
        random_phase(150);

        // ---- instance B: RVALID_LAT=3, MAX_OUTSTANDING=2 ----
        sel = 1'b1;
        preload();

        gpat  = '0;
        acc_n = 0;
        cyc   = 0;
        rv_n  = 0;
        peak  = 0;
        while (acc_n < 4 && cyc < 20) begin
            step(1'b1, 1'b0, 32'(acc_n * 4), 4'hF, '0, 1'b0, a, g, rv, rd);
            if (cyc < 5) gpat[cyc] = g;
            if (a) acc_n++;
            if (rv) rv_n++;
            if (cur_out > peak) peak = cur_out;
            cyc++;
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, '0, '0, '0, 1'b0, a, g, rv, rd);
            if (rv) rv_n++;
        end
        chk("bp_accepted", acc_n, 32'd4);
        chk("bp_gnt_pattern", 32'(gpat), 32'b11011);
        chk("bp_peak_outstanding", peak, 32'd2);
        chk("bp_rvalid_count", rv_n, 32'd4);

        step(1'b1, 1'b0, 32'h8, 4'hF, '0, 1'b0, a, g, rv, rd);
        g_n  = 0;
        rv_n = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 32'hC, 4'hF, '0, 1'b1, a, g, rv, rd);
            if (g) g_n++;
            if (rv) begin
                rv_n++;
                chk("stall_resp_cycle", 32'(i), 32'd1);
                chk("stall_resp_data", rd, 32'h1000_0002);
            end
        end
        chk("stall_gnt_count", g_n, 32'd0);
        chk("stall_rvalid_count", rv_n, 32'd1);
        idle(4);

        random_phase(150);

        issue(1'b1, 32'h10, 4'hF, 32'h5A5A_1234);
        idle(4);
        step(1'b1, 1'b0, 32'h4, 4'hF, '0, 1'b0, a, g, rv, rd);
        step(1'b1, 1'b0, 32'h8, 4'hF, '0, 1'b0, a, g, rv, rd);
        chk("pre_reset_outstanding", 32'(cur_out), 32'd2);
        do_reset();
        rv_n = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, '0, '0, '0, 1'b0, a, g, rv, rd);
            if (rv) rv_n++;
        end
        chk("post_reset_rvalid_count", rv_n, 32'd0);
        got = '0;
        step(1'b1, 1'b0, 32'h10, 4'hF, '0, 1'b0, a, g, rv, rd);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, '0, '0, '0, 1'b0, a, g, rv, rd);
            if (rv) got = rd;
        end
        chk("retained_after_reset", got, 32'h5A5A_1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
